// File: rtl/debug_slave_sysclk_cmd_gen.sv
// Purpose : clk-side decoder for JTAG debug slave commands; syncs vs_uir/vs_udr, captures sr into jdo,
//           issues one-hot take_action/take_no_action strobes indexed by the captured IR.
// Latency : jdo valid SYNC_STAGES edges after vs_udr is first sampled high, strobe one edge later.
// Backpressure: ACK_MODE=1 holds the strobe until act_ack; udr edges arriving while busy are dropped
//           and flagged in the sticky overrun bit.
// Ports   : clk/reset (async active-high); ir_in, sr, vs_uir, vs_udr from TCK domain;
//           act_ack, overrun_clr from consumer; jdo, take_action, take_no_action, busy, overrun,
//           cmd_count to consumer.
module debug_slave_sysclk_cmd_gen #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int ACTION_BIT  = 35,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_MODE    = 0,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DATA_W-1:0]    sr,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic                 act_ack,
  input  logic                 overrun_clr,
  output logic [DATA_W-1:0]    jdo,
  output logic [(1<<IR_W)-1:0] take_action,
  output logic [(1<<IR_W)-1:0] take_no_action,
  output logic                 busy,
  output logic                 overrun,
  output logic [CNT_W-1:0]     cmd_count
);

  localparam int NCMD = 1 << IR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic               uir_dly_q, uir_dly_d;
  logic               udr_dly_q, udr_dly_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [IR_W-1:0]    ir_cap_q, ir_cap_d;
  logic [DATA_W-1:0]  jdo_q, jdo_d;
  logic [NCMD-1:0]    take_action_q, take_action_d;
  logic [NCMD-1:0]    take_no_action_q, take_no_action_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   cmd_count_q, cmd_count_d;

  logic uir_edge;
  logic udr_edge;

  // Delay flop sits after the last sync stage so a long TCK pulse gives a single edge.
  assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
  assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;

  always_comb begin
    uir_sync_d       = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_sync_d       = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_dly_d        = uir_sync_q[SYNC_STAGES-1];
    udr_dly_d        = udr_sync_q[SYNC_STAGES-1];
    state_d          = state_q;
    ir_d             = uir_edge ? ir_in : ir_q;
    ir_cap_d         = ir_cap_q;
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    cmd_count_d      = cmd_count_q;
    overrun_d        = overrun_q;

    case (state_q)
      IDLE: begin
        if (udr_edge) begin
          jdo_d    = sr;
          // A uir edge in the same cycle must win, so take ir_in directly.
          ir_cap_d = uir_edge ? ir_in : ir_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (jdo_q[ACTION_BIT]) take_action_d[ir_cap_q]    = 1'b1;
        else                   take_no_action_d[ir_cap_q] = 1'b1;
        cmd_count_d = cmd_count_q + CNT_W'(1);
        state_d     = (ACK_MODE != 0) ? WAIT_ACK : IDLE;
      end
      WAIT_ACK: begin
        if (act_ack) begin
          state_d = IDLE;
        end else begin
          take_action_d    = take_action_q;
          take_no_action_d = take_no_action_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (udr_edge && (state_q != IDLE)) overrun_d = 1'b1;
    else if (overrun_clr)              overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      uir_sync_q       <= '0;
      udr_sync_q       <= '0;
      uir_dly_q        <= 1'b0;
      udr_dly_q        <= 1'b0;
      ir_q             <= '0;
      ir_cap_q         <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overrun_q        <= 1'b0;
      cmd_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      uir_sync_q       <= uir_sync_d;
      udr_sync_q       <= udr_sync_d;
      uir_dly_q        <= uir_dly_d;
      udr_dly_q        <= udr_dly_d;
      ir_q             <= ir_d;
      ir_cap_q         <= ir_cap_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overrun_q        <= overrun_d;
      cmd_count_q      <= cmd_count_d;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;
  assign cmd_count      = cmd_count_q;

endmodule

// File: tb/tb_debug_slave_sysclk_cmd_gen.sv
// Purpose : directed bench for debug_slave_sysclk_cmd_gen; three instances share stimulus:
//           u0 single-cycle strobes, u1 hold-until-ack, u2 4-bit command counter.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: act_ack held high except during the hold-until-ack scenarios.
module tb_debug_slave_sysclk_cmd_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir, vs_udr, act_ack, overrun_clr;

  logic [37:0] u0_jdo, u1_jdo, u2_jdo;
  logic [3:0]  u0_ta, u0_tna, u1_ta, u1_tna, u2_ta, u2_tna;
  logic        u0_busy, u1_busy, u2_busy;
  logic        u0_ovr, u1_ovr, u2_ovr;
  logic [15:0] u0_cnt, u1_cnt;
  logic [3:0]  u2_cnt;

  int checks = 0;
  int errors = 0;
  int ncmd   = 0;

  always #5 clk = ~clk;

  debug_slave_sysclk_cmd_gen u0 (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .act_ack(act_ack), .overrun_clr(overrun_clr), .jdo(u0_jdo), .take_action(u0_ta),
    .take_no_action(u0_tna), .busy(u0_busy), .overrun(u0_ovr), .cmd_count(u0_cnt));

  debug_slave_sysclk_cmd_gen #(.ACK_MODE(1)) u1 (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .act_ack(act_ack), .overrun_clr(overrun_clr), .jdo(u1_jdo), .take_action(u1_ta),
    .take_no_action(u1_tna), .busy(u1_busy), .overrun(u1_ovr), .cmd_count(u1_cnt));

  debug_slave_sysclk_cmd_gen #(.CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .act_ack(act_ack), .overrun_clr(overrun_clr), .jdo(u2_jdo), .take_action(u2_ta),
    .take_no_action(u2_tna), .busy(u2_busy), .overrun(u2_ovr), .cmd_count(u2_cnt));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_ir(input logic [1:0] ir);
    @(negedge clk);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (2) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raises vs_udr and returns on the falling edge after N+1 with vs_udr still high.
  task automatic udr_raise(input logic [37:0] d);
    sr = d;
    @(negedge clk);
    vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_basic(input logic [1:0] ir, input logic [37:0] d);
    logic [3:0] onehot;
    onehot = 4'b0001 << ir;
    send_ir(ir);
    udr_raise(d);
    vs_udr = 1'b0;
    check("pre_strobe", {u0_ta, u0_tna}, 8'h00);
    @(negedge clk);                            // after N+2
    check("jdo_cap", u0_jdo, d);
    check("busy_issue", u0_busy, 1);
    check("no_early_strobe", {u0_ta, u0_tna}, 8'h00);
    @(negedge clk);                            // after N+3
    ncmd++;
    if (d[35]) begin
      check("ta", u0_ta, onehot);
      check("tna_idle", u0_tna, 0);
    end else begin
      check("tna", u0_tna, onehot);
      check("ta_idle", u0_ta, 0);
    end
    check("cnt", u0_cnt, ncmd);
    @(negedge clk);                            // after N+4
    check("strobe_1cyc", {u0_ta, u0_tna}, 8'h00);
    check("busy_done", u0_busy, 0);
  endtask

  initial begin
    int nstrobe;
    reset = 1'b1; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    act_ack = 1'b1; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_jdo", u0_jdo, 0);
    check("rst_strobes", {u0_ta, u0_tna}, 8'h00);
    check("rst_busy", u0_busy, 0);
    check("rst_ovr", u0_ovr, 0);
    check("rst_cnt", u0_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic action and no-action commands.
    run_basic(2'd2, 38'h8_0000_1234);
    run_basic(2'd1, 38'h0_0000_5678);

    // Hold-until-ack: strobe held 6 cycles, ack driven 5 cycles after the strobe.
    act_ack = 1'b0;
    send_ir(2'd3);
    udr_raise(38'h8_0000_00C3);
    vs_udr = 1'b0;
    @(negedge clk);
    @(negedge clk);                            // strobe edge S
    ncmd++;
    check("ack_ta_s0", u1_ta, 4'b1000);
    check("ack_busy_s0", u1_busy, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("ack_ta_hold", u1_ta, 4'b1000);
      check("ack_busy_hold", u1_busy, 1);
    end
    act_ack = 1'b1;
    @(negedge clk);
    check("ack_ta_clr", u1_ta, 0);
    check("ack_busy_clr", u1_busy, 0);

    // Overrun while waiting for ack.
    act_ack = 1'b0;
    send_ir(2'd3);
    udr_raise(38'h0_0000_00AA);
    vs_udr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ncmd++;
    check("ovr_first_tna", u1_tna, 4'b1000);
    repeat (2) @(negedge clk);
    udr_raise(38'h8_0000_0BBB);
    vs_udr = 1'b0;
    @(negedge clk);                            // after N'+2
    check("ovr_set", u1_ovr, 1);
    check("ovr_jdo_kept", u1_jdo, 38'h0_0000_00AA);
    check("ovr_u0_capt", u0_jdo, 38'h8_0000_0BBB);
    ncmd++;
    @(negedge clk);
    check("ovr_no_2nd_ta", u1_ta, 0);
    check("ovr_tna_held", u1_tna, 4'b1000);
    check("u0_no_ovr", u0_ovr, 0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", u1_ovr, 0);
    udr_raise(38'h0_0000_0CCC);
    vs_udr = 1'b0;
    overrun_clr = 1'b1;                        // sampled on the same edge as the drop
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_set_wins", u1_ovr, 1);
    check("ovr_jdo_kept2", u1_jdo, 38'h0_0000_00AA);
    ncmd++;
    act_ack = 1'b1;
    @(negedge clk);
    check("ovr_ack_tna", u1_tna, 0);
    check("ovr_ack_busy", u1_busy, 0);
    check("u0_cnt_mid", u0_cnt, ncmd);

    // Reset in the middle of a command.
    send_ir(2'd2);
    udr_raise(38'h8_0000_0D0D);
    vs_udr = 1'b0;
    @(negedge clk);                            // captured, issuing next edge
    reset = 1'b1;
    @(negedge clk);
    check("abort_jdo", u0_jdo, 0);
    check("abort_strobes", {u0_ta, u0_tna}, 8'h00);
    check("abort_cnt", u0_cnt, 0);
    check("abort_busy", u0_busy, 0);
    check("abort_ovr1", u1_ovr, 0);
    reset = 1'b0;
    ncmd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_quiet", {u0_ta, u0_tna}, 8'h00);
    end
    run_basic(2'd2, 38'h8_0000_1234);

    // 4-bit counter wrap after 17 commands.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ncmd = 0;
    for (int i = 0; i < 17; i++) begin
      logic [37:0] d;
      d = 38'h0_0000_0100 + 38'(i);
      d[35] = i[0];
      run_basic(2'(i), d);
    end
    check("cnt4_wrap", u2_cnt, 1);
    check("cnt16_17", u0_cnt, 17);

    // A long vs_udr pulse yields one strobe.
    send_ir(2'd1);
    sr = 38'h8_0000_0777;
    @(negedge clk);
    vs_udr  = 1'b1;
    nstrobe = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 9) vs_udr = 1'b0;
      if ((|u0_ta) || (|u0_tna)) nstrobe++;
    end
    check("long_pulse_strobes", nstrobe, 1);
    check("long_pulse_cnt", u0_cnt, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
